// File: rtl/multi_cycle_core_if.sv
// Instruction and data memory bus for multi_cycle_core.
// master modport: the core side (drives requests, receives acks).
// slave modport: the memory side (receives requests, drives acks).
//   imem_req/imem_addr     : instruction fetch request and word address
//   imem_ack/imem_rdata    : fetch acknowledge, instruction word valid with ack
//   dmem_req/dmem_we       : data access request, write enable
//   dmem_addr/dmem_wdata   : data word address and store data
//   dmem_ack/dmem_rdata    : data acknowledge, load data valid with ack
interface multi_cycle_core_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [15:0]           imem_rdata;
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle 16-bit core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : instruction/data memory bus (master side)
//   sw    : switch inputs, visible as the highest register
//   Led   : low bits of register 1, registered
//   state : current FSM state code (FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4)
module multi_cycle_core #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int REG_WIDTH    = 3,
    parameter int IMM_WIDTH    = 7,
    parameter int SWITCH_WIDTH = 8,
    parameter int LED_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multi_cycle_core_if.master      bus,
    input  logic [SWITCH_WIDTH-1:0] sw,
    output logic [LED_WIDTH-1:0]    Led,
    output logic [2:0]              state
);
    localparam int NUM_REGS = 2 ** REG_WIDTH;
    localparam logic [REG_WIDTH-1:0] SW_REG = REG_WIDTH'(NUM_REGS - 1);
    localparam logic [REG_WIDTH-1:0] LED_REG = REG_WIDTH'(1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_ADDI = 3'd4,
        OP_LW   = 3'd5,
        OP_SW   = 3'd6,
        OP_BEQ  = 3'd7
    } opcode_t;

    state_t                cur_state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           ir;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] mdr;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    opcode_t               opcode;
    logic [REG_WIDTH-1:0]  rs;
    logic [REG_WIDTH-1:0]  rt;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  branch_taken;
    logic [REG_WIDTH-1:0]  wb_dest;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_enable;
    logic                  fetch_req;
    logic                  mem_req;
    logic                  mem_we;

    assign opcode = opcode_t'(ir[15:13]);
    assign rs     = ir[12:10];
    assign rt     = ir[9:7];
    assign rd     = ir[6:4];
    assign state  = cur_state;

    // Register 0 is hard zero and the top register mirrors the switches,
    // so the storage behind those two indices is never consulted.
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (rs == '0) begin
            rs_data = '0;
        end else if (rs == SW_REG) begin
            rs_data = DATA_WIDTH'(sw);
        end
        if (rt == '0) begin
            rt_data = '0;
        end else if (rt == SW_REG) begin
            rt_data = DATA_WIDTH'(sw);
        end
    end

    // ALU: R-type ops use B, ADDI/LW/SW use the immediate for the address sum.
    always_comb begin
        alu_result = a + imm_ext;
        case (opcode)
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            default: alu_result = a + imm_ext;
        endcase
    end

    // PC already points at the next instruction by EXEC, so PC+imm is PC+1+imm
    // relative to the branch itself.
    assign branch_taken = (opcode == OP_BEQ) && (a == b);

    // R-type writes rd, ADDI/LW write rt; writes to r0 and the switch register vanish.
    always_comb begin
        wb_dest   = (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) ? rd : rt;
        wb_data   = (opcode == OP_LW) ? mdr : alu_out;
        wb_enable = (cur_state == WB) && (wb_dest != '0) && (wb_dest != SW_REG);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic and bus request strobes. Acks only matter in the state
    // that issued the matching request.
    always_comb begin
        next_state = cur_state;
        fetch_req  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (cur_state)
            FETCH: begin
                fetch_req = 1'b1;
                if (bus.imem_ack) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = EXEC;
            end
            EXEC: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    next_state = MEM;
                end else if (opcode == OP_BEQ) begin
                    next_state = FETCH;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (bus.dmem_ack) begin
                    next_state = (opcode == OP_LW) ? WB : FETCH;
                end
            end
            WB: begin
                next_state = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // Gating with reset keeps the strobes low while reset holds the FSM in FETCH.
    assign bus.imem_req   = fetch_req & ~reset;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = mem_req & ~reset;
    assign bus.dmem_we    = mem_we & ~reset;
    assign bus.dmem_addr  = alu_out[ADDR_WIDTH-1:0];
    assign bus.dmem_wdata = b;

    // Datapath registers, register file and LED latch. Led is written on the
    // same edge as register 1 so it never lags the register contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm_ext <= '0;
            alu_out <= '0;
            mdr     <= '0;
            Led     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (cur_state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir <= bus.imem_rdata;
                        pc <= pc + ADDR_WIDTH'(1);
                    end
                end
                DECODE: begin
                    a       <= rs_data;
                    b       <= rt_data;
                    imm_ext <= {{(DATA_WIDTH-IMM_WIDTH){ir[IMM_WIDTH-1]}}, ir[IMM_WIDTH-1:0]};
                end
                EXEC: begin
                    alu_out <= alu_result;
                    if (branch_taken) begin
                        pc <= pc + imm_ext[ADDR_WIDTH-1:0];
                    end
                end
                MEM: begin
                    if (bus.dmem_ack && opcode == OP_LW) begin
                        mdr <= bus.dmem_rdata;
                    end
                end
                WB: begin
                    if (wb_enable) begin
                        regs[wb_dest] <= wb_data;
                        if (wb_dest == LED_REG) begin
                            Led <= wb_data[LED_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_cycle_core.sv
// Testbench for multi_cycle_core: drives instructions one at a time over the
// memory bus with random ack delays and spurious acks, and compares fetch
// addresses, latency, data accesses and Led against an ISA-level model.
module tb_multi_cycle_core;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw;
    logic [7:0] Led;
    logic [2:0] state;

    multi_cycle_core_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    multi_cycle_core #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .REG_WIDTH(3),
        .IMM_WIDTH(7), .SWITCH_WIDTH(8), .LED_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.master),
        .sw(sw), .Led(Led), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ISA-level architectural state.
    logic [15:0] m_regs [8];
    logic [15:0] m_pc;

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        if (idx == 3'd0) return 16'h0000;
        if (idx == 3'd7) return {8'h00, sw};
        return m_regs[idx];
    endfunction

    function automatic void m_write(input logic [2:0] idx, input logic [15:0] val);
        if (idx != 3'd0 && idx != 3'd7) m_regs[idx] = val;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_pc = 16'h0000;
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [2:0] rd);
        return {op, rs, rt, rd, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input int imm);
        logic [6:0] i7;
        i7 = 7'(imm);
        return {op, rs, rt, i7};
    endfunction

    // Runs one instruction from its FETCH to the next FETCH, acking the fetch
    // after iwait cycles and the data access after dwait cycles.
    task automatic drive_instr(input logic [15:0] instr, input int iwait,
                               input int dwait, input logic [15:0] load_data);
        logic [2:0]  op, rs, rt, rd;
        logic [15:0] a, b, imm, exp_addr, next_pc;
        logic        exp_mem, exp_we;
        int          exp_cycles;
        logic        fetched, done, mem_seen, both, unstable;
        int          fwait, dcnt, mem_cycles, writes, cycles;
        logic [15:0] o_addr, o_wdata;
        logic        o_we;

        op  = instr[15:13];
        rs  = instr[12:10];
        rt  = instr[9:7];
        rd  = instr[6:4];
        imm = {{9{instr[6]}}, instr[6:0]};
        a   = m_read(rs);
        b   = m_read(rt);
        exp_mem    = (op == 3'd5) || (op == 3'd6);
        exp_we     = (op == 3'd6);
        exp_addr   = a + imm;
        exp_cycles = ((op == 3'd7) ? 3 : (op == 3'd5) ? 5 : 4) + iwait + (exp_mem ? dwait : 0);
        next_pc    = m_pc + 16'd1;
        if (op == 3'd7 && a == b) next_pc = m_pc + 16'd1 + imm;

        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc)
            $display("[TB] FAIL fetch_addr: req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, m_pc);
        else n_pass++;

        fetched = 0; done = 0; mem_seen = 0; both = 0; unstable = 0;
        fwait = 0; dcnt = 0; mem_cycles = 0; writes = 0; cycles = 0;
        o_addr = '0; o_wdata = '0; o_we = 0;
        while (!done && cycles < 64) begin
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (bus.imem_req && bus.dmem_req) both = 1;
            if (bus.imem_req && fetched) begin
                done = 1;
            end else begin
                if (bus.imem_req) begin
                    if (fwait == iwait) begin
                        bus.imem_ack = 1'b1; bus.imem_rdata = instr; fetched = 1;
                    end else fwait++;
                end else if ($urandom_range(3) == 0) begin
                    bus.imem_ack = 1'b1; bus.imem_rdata = 16'($urandom);
                end
                if (bus.dmem_req) begin
                    if (!mem_seen) begin
                        mem_seen = 1; o_addr = bus.dmem_addr; o_we = bus.dmem_we; o_wdata = bus.dmem_wdata;
                    end else if (o_addr !== bus.dmem_addr || o_we !== bus.dmem_we || o_wdata !== bus.dmem_wdata) begin
                        unstable = 1;
                    end
                    mem_cycles++;
                    if (dcnt == dwait) begin
                        bus.dmem_ack = 1'b1; bus.dmem_rdata = load_data;
                        if (bus.dmem_we) writes++;
                    end else dcnt++;
                end else if ($urandom_range(3) == 0) begin
                    bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'($urandom);
                end
                @(posedge clk);
                @(negedge clk);
                cycles++;
            end
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        case (op)
            3'd0: m_write(rd, a + b);
            3'd1: m_write(rd, a - b);
            3'd2: m_write(rd, a & b);
            3'd3: m_write(rd, a | b);
            3'd4: m_write(rt, a + imm);
            3'd5: m_write(rt, load_data);
            default: ;
        endcase
        m_pc = next_pc;

        n_checks++;
        if (!done) $display("[TB] FAIL timeout: instr=%h no next fetch within 64 cycles", instr);
        else n_pass++;
        n_checks++;
        if (cycles !== exp_cycles) $display("[TB] FAIL latency: instr=%h got %0d cycles expected %0d", instr, cycles, exp_cycles);
        else n_pass++;
        n_checks++;
        if (both) $display("[TB] FAIL req_overlap: instr=%h got both requests expected exclusive", instr);
        else n_pass++;
        n_checks++;
        if (mem_seen !== exp_mem) $display("[TB] FAIL mem_access: instr=%h got %b expected %b", instr, mem_seen, exp_mem);
        else n_pass++;
        if (exp_mem) begin
            n_checks++;
            if (o_addr !== exp_addr || o_we !== exp_we)
                $display("[TB] FAIL mem_addr_we: got %h/%b expected %h/%b", o_addr, o_we, exp_addr, exp_we);
            else n_pass++;
            n_checks++;
            if (exp_we && o_wdata !== b) $display("[TB] FAIL mem_wdata: got %h expected %h", o_wdata, b);
            else n_pass++;
            n_checks++;
            if (unstable || mem_cycles !== dwait + 1)
                $display("[TB] FAIL mem_hold: unstable=%b cycles=%0d expected stable for %0d", unstable, mem_cycles, dwait + 1);
            else n_pass++;
        end
        n_checks++;
        if (writes !== (exp_we ? 1 : 0)) $display("[TB] FAIL write_count: got %0d expected %0d", writes, exp_we ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (Led !== m_regs[1][7:0]) $display("[TB] FAIL led: instr=%h got %h expected %h", instr, Led, m_regs[1][7:0]);
        else n_pass++;
        n_checks++;
        if (bus.imem_addr !== m_pc) $display("[TB] FAIL next_pc: got %h expected %h", bus.imem_addr, m_pc);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if (state !== 3'd0 || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0)
            $display("[TB] FAIL reset_outputs: state=%0d ireq=%b dreq=%b we=%b expected 0/0/0/0", state, bus.imem_req, bus.dmem_req, bus.dmem_we);
        else n_pass++;
        n_checks++;
        if (Led !== 8'h00 || bus.imem_addr !== 16'h0000)
            $display("[TB] FAIL reset_led_pc: led=%h pc=%h expected 00/0000", Led, bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000)
            $display("[TB] FAIL first_fetch: req=%b addr=%h expected 1/0000", bus.imem_req, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_led_sequence();
        drive_instr(enc_i(3'd4, 3'd0, 3'd1, 5), 0, 0, 16'h0);
        drive_instr(enc_r(3'd0, 3'd1, 3'd1, 3'd1), 0, 0, 16'h0);
        n_checks++;
        if (Led !== 8'h0A || bus.imem_addr !== 16'd2)
            $display("[TB] FAIL led_sequence: led=%h pc=%h expected 0a/0002", Led, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_switch_reg();
        sw = 8'h23;
        drive_instr(enc_r(3'd0, 3'd7, 3'd0, 3'd1), 1, 0, 16'h0);
        n_checks++;
        if (Led !== 8'h23) $display("[TB] FAIL sw_read: led=%h expected 23", Led);
        else n_pass++;
        drive_instr(enc_i(3'd4, 3'd0, 3'd7, 1), 0, 0, 16'h0);
        drive_instr(enc_r(3'd0, 3'd0, 3'd0, 3'd1), 0, 0, 16'h0);
        drive_instr(enc_r(3'd0, 3'd7, 3'd0, 3'd1), 0, 0, 16'h0);
        n_checks++;
        if (Led !== 8'h23) $display("[TB] FAIL sw_write_ignored: led=%h expected 23", Led);
        else n_pass++;
    endtask

    task automatic test_store_load();
        drive_instr(enc_i(3'd4, 3'd0, 3'd1, 10), 0, 0, 16'h0);
        drive_instr(enc_i(3'd6, 3'd0, 3'd1, 3), 0, 3, 16'h0);
        drive_instr(enc_i(3'd5, 3'd0, 3'd2, 3), 2, 1, 16'h000A);
        drive_instr(enc_i(3'd6, 3'd0, 3'd2, 4), 0, 0, 16'h0);
        drive_instr(enc_r(3'd0, 3'd2, 3'd2, 3'd1), 0, 0, 16'h0);
        n_checks++;
        if (Led !== 8'h14) $display("[TB] FAIL load_value: led=%h expected 14", Led);
        else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        drive_instr(enc_i(3'd4, 3'd0, 3'd1, 1), 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) drive_instr(16'h0000, 0, 0, 16'h0);
        drive_instr(enc_i(3'd7, 3'd0, 3'd0, -1), 0, 0, 16'h0);
        n_checks++;
        if (bus.imem_addr !== 16'd4) $display("[TB] FAIL beq_taken: pc=%h expected 0004", bus.imem_addr);
        else n_pass++;
        drive_instr(enc_i(3'd7, 3'd1, 3'd0, 9), 1, 0, 16'h0);
        n_checks++;
        if (bus.imem_addr !== 16'd5) $display("[TB] FAIL beq_not_taken: pc=%h expected 0005", bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        drive_instr(enc_i(3'd4, 3'd0, 3'd1, -1), 0, 0, 16'h0);
        n_checks++;
        if (Led !== 8'hFF) $display("[TB] FAIL addi_neg: led=%h expected ff", Led);
        else n_pass++;
        drive_instr(enc_i(3'd4, 3'd1, 3'd1, 1), 0, 0, 16'h0);
        n_checks++;
        if (Led !== 8'h00) $display("[TB] FAIL addi_wrap: led=%h expected 00", Led);
        else n_pass++;
        drive_instr(enc_i(3'd6, 3'd0, 3'd1, 0), 0, 0, 16'h0);
        do_reset();
        drive_instr(enc_i(3'd7, 3'd0, 3'd0, -2), 0, 0, 16'h0);
        n_checks++;
        if (bus.imem_addr !== 16'hFFFF) $display("[TB] FAIL branch_wrap: pc=%h expected ffff", bus.imem_addr);
        else n_pass++;
        drive_instr(16'h0000, 0, 0, 16'h0);
        n_checks++;
        if (bus.imem_addr !== 16'h0000) $display("[TB] FAIL pc_wrap: pc=%h expected 0000", bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int i = 0; i < 80; i++) begin
            sw    = 8'($urandom);
            instr = 16'($urandom);
            drive_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        end
        n_checks++;
        if (state !== 3'd0) $display("[TB] FAIL random_end_state: state=%0d expected 0", state);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        drive_instr(enc_i(3'd4, 3'd0, 3'd1, 21), 0, 0, 16'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = enc_i(3'd6, 3'd0, 3'd1, 9);
        @(posedge clk);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (bus.dmem_req !== 1'b1 || state !== 3'd3)
            $display("[TB] FAIL enter_mem: dreq=%b state=%0d expected 1/3", bus.dmem_req, state);
        else n_pass++;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || state !== 3'd0 || bus.imem_req !== 1'b0)
            $display("[TB] FAIL reset_mid_mem: dreq=%b we=%b state=%0d ireq=%b expected 0/0/0/0", bus.dmem_req, bus.dmem_we, state, bus.imem_req);
        else n_pass++;
        n_checks++;
        if (Led !== 8'h00 || bus.imem_addr !== 16'h0000)
            $display("[TB] FAIL reset_mid_mem_state: led=%h pc=%h expected 00/0000", Led, bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000)
            $display("[TB] FAIL refetch_after_reset: req=%b addr=%h expected 1/0000", bus.imem_req, bus.imem_addr);
        else n_pass++;
        for (int r = 1; r < 7; r++) drive_instr(enc_i(3'd6, 3'd0, 3'(r), r), 0, 0, 16'h0);
    endtask

    initial begin
        sw             = 8'h00;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        m_reset();
        test_reset();
        test_led_sequence();
        test_switch_reg();
        test_store_load();
        test_branch();
        test_wrap();
        test_random();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
